clock_divider_core: RTL

- Divider engine fed by the clockDivider AXI4-Lite register block; it consumes that block's control registers and returns a status word for readback.
- Generates a programmable-period, programmable-duty divided output `div_out` and a one-cycle `div_tick` at the start of each period.
- All logic runs in the single ACLK domain.
- Configuration changes are glitch-free: they are deferred to a period boundary.

---
 rtl/clock_divider_core.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/clock_divider_core.sv
// Programmable-period, programmable-duty clock divider engine.
// Config changes are held in a shadow set and applied at period boundaries.
module clock_divider_core #(
   parameter int CNT_WIDTH  = 32,
   parameter int PCNT_WIDTH = 24
) (
   input  logic                 ACLK,
   input  logic                 ARESET,
   input  logic                 cfg_enable,
   input  logic                 cfg_invert,
   input  logic [CNT_WIDTH-1:0] cfg_period,
   input  logic [CNT_WIDTH-1:0] cfg_high,
   input  logic                 cfg_update,
   input  logic                 count_clr,
   output logic                 div_out,
   output logic                 div_tick,
   output logic [31:0]          status
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   typedef struct packed {
      logic [CNT_WIDTH-1:0] period;
      logic [CNT_WIDTH-1:0] high;
      logic                 invert;
      logic                 err;
   } cfg_t;

   localparam cfg_t CFG_DEFAULT = '{
      period: CNT_WIDTH'(2),
      high:   CNT_WIDTH'(1),
      invert: 1'b0,
      err:    1'b0
   };

   function automatic cfg_t sanitize(
      input logic [CNT_WIDTH-1:0] p,
      input logic [CNT_WIDTH-1:0] h,
      input logic                 inv
   );
      cfg_t c;
      c.period = p;
      c.high   = h;
      c.invert = inv;
      c.err    = 1'b0;
      if (p < CNT_WIDTH'(2)) begin
         c.period = CNT_WIDTH'(2);
         c.err    = 1'b1;
      end
      if (h == '0 || h >= c.period) begin
         c.high = c.period >> 1;
         c.err  = 1'b1;
      end
      return c;
   endfunction

   state_t                state_q, state_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   cfg_t                  act_q, act_d;
   cfg_t                  shd_q, shd_d;
   cfg_t                  snap;
   logic                  pend_q, pend_d;
   logic [PCNT_WIDTH-1:0] pcnt_q, pcnt_d;
   logic                  out_q, out_d;
   logic                  tick_q, tick_d;
   logic                  boundary;

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         act_q   <= CFG_DEFAULT;
         shd_q   <= '0;
         pend_q  <= 1'b0;
         pcnt_q  <= '0;
         out_q   <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         act_q   <= act_d;
         shd_q   <= shd_d;
         pend_q  <= pend_d;
         pcnt_q  <= pcnt_d;
         out_q   <= out_d;
         tick_q  <= tick_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      act_d    = act_q;
      shd_d    = shd_q;
      pend_d   = pend_q;
      pcnt_d   = pcnt_q;
      out_d    = out_q;
      tick_d   = 1'b0;
      snap     = sanitize(cfg_period, cfg_high, cfg_invert);
      boundary = (state_q != IDLE) &&
                 (cnt_q == act_q.period - CNT_WIDTH'(1));

      unique case (state_q)
         IDLE: begin
            if (cfg_update) act_d = snap;
            if (cfg_enable) begin
               state_d = RUN;
               cnt_d   = '0;
               tick_d  = 1'b1;
               out_d   = ~act_d.invert;
            end else begin
               out_d = act_d.invert;
            end
         end
         RUN, DRAIN: begin
            if (boundary) begin
               cnt_d  = '0;
               pend_d = 1'b0;
               // A strobe on the boundary edge supersedes the shadow
               if (cfg_update) act_d = snap;
               else if (pend_q) act_d = shd_q;
               if (pcnt_q != '1) pcnt_d = pcnt_q + PCNT_WIDTH'(1);
               if (cfg_enable) begin
                  state_d = RUN;
                  tick_d  = 1'b1;
                  out_d   = ~act_d.invert;
               end else begin
                  state_d = IDLE;
                  out_d   = act_d.invert;
               end
            end else begin
               cnt_d = cnt_q + CNT_WIDTH'(1);
               if (cfg_update) begin
                  shd_d  = snap;
                  pend_d = 1'b1;
               end
               out_d   = (cnt_d < act_q.high) ^ act_q.invert;
               state_d = cfg_enable ? RUN : DRAIN;
            end
         end
         default: state_d = IDLE;
      endcase

      if (count_clr) pcnt_d = '0;
   end

   assign div_out  = out_q;
   assign div_tick = tick_q;
   assign status   = {24'(pcnt_q), 5'd0, act_q.err, pend_q,
                      state_q != IDLE};

endmodule
